// File: rtl/sum_product_pipe_pkg.sv
// Shared widths and parameter limits for the (a+b)*(c+d) pipeline.
// Imported by the interface-facing top and its delay line.
package sum_product_pkg;

  localparam int IN_W_MIN       = 2;
  localparam int IN_W_MAX       = 16;
  localparam int MUL_STAGES_MIN = 1;
  localparam int MUL_STAGES_MAX = 4;

  function automatic int sp_sum_w(input int in_w);
    return in_w + 1;
  endfunction

  function automatic int sp_prod_w(input int in_w);
    return 2 * in_w + 2;
  endfunction

endpackage

// File: rtl/sum_product_pipe_if.sv
// Operand/result handshake bundle for sum_product_pipe.
// master = operand source plus result consumer; slave = the pipeline.
interface sum_product_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
);

  logic            in_valid;
  logic            in_ready;
  logic            in_acc;
  logic [IN_W-1:0] a;
  logic [IN_W-1:0] b;
  logic [IN_W-1:0] c;
  logic [IN_W-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] y;
  logic             ovf;

  modport master (
    output in_valid,
    output in_acc,
    output a,
    output b,
    output c,
    output d,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  in_acc,
    input  a,
    input  b,
    input  c,
    input  d,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y,
    output ovf
  );

endinterface

// File: rtl/sum_product_pipe_delay.sv
// Enable-gated shift register with a valid bit per entry.
// Carries the product and its acc tag through the multiplier stages.
module sp_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0] r_v;
  logic [W-1:0]     r_d [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else if (i_en) begin
      r_v[0] <= i_valid;
      r_d[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_v[i] <= r_v[i-1];
        r_d[i] <= r_d[i-1];
      end
    end
  end

  assign o_valid = r_v[DEPTH-1];
  assign o_data  = r_d[DEPTH-1];

endmodule

// File: rtl/sum_product_pipe.sv
// y = (a+b)*(c+d) with global-stall flow control and accumulate mode.
// Stages: operand capture, sums, product delay line, output register.
module sum_product_pipe
  import sum_product_pkg::*;
#(
  parameter int IN_W       = 3,
  parameter int MUL_STAGES = 1,
  parameter int OUT_W      = 8
) (
  input logic          clock,
  input logic          reset,
  sum_product_if.slave bus
);

  localparam int SUM_W  = sp_sum_w(IN_W);
  localparam int PROD_W = sp_prod_w(IN_W);
  localparam int DL_W   = PROD_W + 1;
  localparam int ACC_W  = OUT_W + 1;

  if (IN_W < IN_W_MIN || IN_W > IN_W_MAX) begin : g_bad_in_w
    $error("sum_product_pipe: IN_W out of range");
  end
  if (MUL_STAGES < MUL_STAGES_MIN ||
      MUL_STAGES > MUL_STAGES_MAX) begin : g_bad_stages
    $error("sum_product_pipe: MUL_STAGES out of range");
  end
  if (OUT_W < PROD_W) begin : g_bad_out_w
    $error("sum_product_pipe: OUT_W below 2*IN_W+2");
  end

  logic            w_adv;
  logic            r_op_v;
  logic            r_op_acc;
  logic [IN_W-1:0] r_a;
  logic [IN_W-1:0] r_b;
  logic [IN_W-1:0] r_c;
  logic [IN_W-1:0] r_d;

  logic             r_s0_v;
  logic             r_s0_acc;
  logic [SUM_W-1:0] r_s0;
  logic [SUM_W-1:0] r_s1;

  logic [PROD_W-1:0] w_prod;
  logic              w_dl_v;
  logic [DL_W-1:0]   w_dl_data;
  logic              w_p_acc;
  logic [PROD_W-1:0] w_p;
  logic [ACC_W-1:0]  w_acc_sum;

  logic             r_out_valid;
  logic             r_ovf;
  logic [OUT_W-1:0] r_y;

  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op_v   <= 1'b0;
      r_op_acc <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
    end else if (w_adv) begin
      r_op_v <= bus.in_valid;
      if (bus.in_valid) begin
        r_op_acc <= bus.in_acc;
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_c      <= bus.c;
        r_d      <= bus.d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s0_v   <= 1'b0;
      r_s0_acc <= 1'b0;
      r_s0     <= '0;
      r_s1     <= '0;
    end else if (w_adv) begin
      r_s0_v   <= r_op_v;
      r_s0_acc <= r_op_acc;
      r_s0     <= {1'b0, r_a} + {1'b0, r_b};
      r_s1     <= {1'b0, r_c} + {1'b0, r_d};
    end
  end

  assign w_prod = PROD_W'(r_s0) * PROD_W'(r_s1);

  sp_delay_line #(
    .W     (DL_W),
    .DEPTH (MUL_STAGES)
  ) u_mul_dly (
    .clock   (clock),
    .reset   (reset),
    .i_en    (w_adv),
    .i_valid (r_s0_v),
    .i_data  ({r_s0_acc, w_prod}),
    .o_valid (w_dl_v),
    .o_data  (w_dl_data)
  );

  assign w_p_acc   = w_dl_data[PROD_W];
  assign w_p       = w_dl_data[PROD_W-1:0];
  // Base is the held y even if it was already consumed.
  assign w_acc_sum = {1'b0, r_y} + ACC_W'(w_p);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_dl_v;
      if (w_dl_v) begin
        if (w_p_acc) begin
          r_y   <= w_acc_sum[OUT_W-1:0];
          r_ovf <= r_ovf | w_acc_sum[OUT_W];
        end else begin
          r_y   <= OUT_W'(w_p);
          r_ovf <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_sum_product_pipe.sv
// Directed bench: an 8-bit and a 16-bit output instance share stimulus.
// Results are collected by per-instance monitors and checked against tables.
module tb_sum_product_pipe;

  typedef struct {
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  c;
    logic [2:0]  d;
    logic        acc;
    logic [7:0]  ya;
    logic        oa;
    logic [15:0] yb;
    logic        ob;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic        ovf;
    int          cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  rec_t qa[$];
  rec_t qb[$];
  vec_t tbl[15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sum_product_if #(.IN_W(3), .OUT_W(8))  ifa ();
  sum_product_if #(.IN_W(3), .OUT_W(16)) ifb ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_acc    = ifa.in_acc;
  assign ifb.a         = ifa.a;
  assign ifb.b         = ifa.b;
  assign ifb.c         = ifa.c;
  assign ifb.d         = ifa.d;
  assign ifb.out_ready = ifa.out_ready;

  sum_product_pipe #(
    .IN_W(3), .MUL_STAGES(1), .OUT_W(8)
  ) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (ifa)
  );

  sum_product_pipe #(
    .IN_W(3), .MUL_STAGES(1), .OUT_W(16)
  ) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (ifb)
  );

  always @(negedge clk) begin : mon_a
    rec_t r;
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      r.y   = 16'(ifa.y);
      r.ovf = ifa.ovf;
      r.cyc = cyc;
      qa.push_back(r);
    end
  end

  always @(negedge clk) begin : mon_b
    rec_t r;
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      r.y   = ifb.y;
      r.ovf = ifb.ovf;
      r.cyc = cyc;
      qb.push_back(r);
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] c, input logic [2:0] d,
                      input logic acc);
    logic ok;
    ifa.in_valid = 1'b1;
    ifa.in_acc   = acc;
    ifa.a = a;
    ifa.b = b;
    ifa.c = c;
    ifa.d = d;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = ifa.in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accepted", 32'(ok), 32'd1);
    acc_cyc = cyc;
  endtask

  task automatic idle();
    ifa.in_valid = 1'b0;
    ifa.in_acc   = 1'b1;
    ifa.a = 3'd7;
    ifa.b = 3'd7;
    ifa.c = 3'd7;
    ifa.d = 3'd7;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] stall_exp [4];
    int t0;

    tbl[0]  = '{3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 8'd196, 1'b0, 16'd196, 1'b0};
    tbl[1]  = '{3'd1, 3'd1, 3'd1, 3'd1, 1'b1, 8'd200, 1'b0, 16'd200, 1'b0};
    tbl[2]  = '{3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 8'd140, 1'b1, 16'd396, 1'b0};
    tbl[3]  = '{3'd0, 3'd1, 3'd0, 3'd1, 1'b0, 8'd1,   1'b0, 16'd1,   1'b0};
    tbl[4]  = '{3'd1, 3'd2, 3'd3, 3'd4, 1'b0, 8'd21,  1'b0, 16'd21,  1'b0};
    tbl[5]  = '{3'd0, 3'd0, 3'd5, 3'd5, 1'b0, 8'd0,   1'b0, 16'd0,   1'b0};
    tbl[6]  = '{3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 8'd196, 1'b0, 16'd196, 1'b0};
    tbl[7]  = '{3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 8'd136, 1'b1, 16'd392, 1'b0};
    tbl[8]  = '{3'd0, 3'd1, 3'd0, 3'd1, 1'b0, 8'd1,   1'b0, 16'd1,   1'b0};
    tbl[9]  = '{3'd3, 3'd0, 3'd0, 3'd2, 1'b1, 8'd7,   1'b0, 16'd7,   1'b0};
    tbl[10] = '{3'd7, 3'd7, 3'd0, 3'd0, 1'b1, 8'd7,   1'b0, 16'd7,   1'b0};
    tbl[11] = '{3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 8'd203, 1'b0, 16'd203, 1'b0};
    tbl[12] = '{3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 8'd143, 1'b1, 16'd399, 1'b0};
    tbl[13] = '{3'd6, 3'd5, 3'd4, 3'd3, 1'b1, 8'd220, 1'b1, 16'd476, 1'b0};
    tbl[14] = '{3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'd0,   1'b0, 16'd0,   1'b0};

    stall_exp[0] = 16'd1;
    stall_exp[1] = 16'd2;
    stall_exp[2] = 16'd6;
    stall_exp[3] = 16'd12;

    rst = 1'b1;
    ifa.out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid_a", 32'(ifa.out_valid), 32'd0);
    check("rst_y_a", 32'(ifa.y), 32'd0);
    check("rst_ovf_a", 32'(ifa.ovf), 32'd0);
    check("rst_in_ready_a", 32'(ifa.in_ready), 32'd1);
    check("rst_out_valid_b", 32'(ifb.out_valid), 32'd0);
    check("rst_y_b", 32'(ifb.y), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single beat: latency and value.
    send(3'd7, 3'd7, 3'd7, 3'd7, 1'b0);
    t0 = acc_cyc;
    idle();
    cycles(8);
    check("lat_count", 32'(qa.size()), 32'd1);
    if (qa.size() > 0) begin
      check("lat_y", 32'(qa[0].y), 32'd196);
      check("lat_ovf", 32'(qa[0].ovf), 32'd0);
      check("lat_edges", 32'(qa[0].cyc - t0), 32'd3);
    end
    qa.delete();
    qb.delete();

    // Back-to-back streaming through the table.
    foreach (tbl[i]) begin
      send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].acc);
    end
    idle();
    cycles(8);
    check("tbl_count_a", 32'(qa.size()), 32'd15);
    check("tbl_count_b", 32'(qb.size()), 32'd15);
    for (int i = 0; i < 15 && i < qa.size(); i++) begin
      check($sformatf("tbl%0d_y_a", i), 32'(qa[i].y), 32'(tbl[i].ya));
      check($sformatf("tbl%0d_ovf_a", i), 32'(qa[i].ovf), 32'(tbl[i].oa));
      if (i > 0)
        check($sformatf("tbl%0d_gap", i),
              32'(qa[i].cyc - qa[i-1].cyc), 32'd1);
    end
    for (int i = 0; i < 15 && i < qb.size(); i++) begin
      check($sformatf("tbl%0d_y_b", i), 32'(qb[i].y), 32'(tbl[i].yb));
      check($sformatf("tbl%0d_ovf_b", i), 32'(qb[i].ovf), 32'(tbl[i].ob));
    end
    qa.delete();
    qb.delete();

    // Stall: four beats fill the pipe while the consumer waits.
    ifa.out_ready = 1'b0;
    send(3'd1, 3'd0, 3'd1, 3'd0, 1'b0);
    send(3'd1, 3'd1, 3'd1, 3'd0, 1'b0);
    send(3'd2, 3'd1, 3'd1, 3'd1, 1'b0);
    send(3'd3, 3'd0, 3'd2, 3'd2, 1'b0);
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(ifa.in_ready), 32'd0);
      check("stall_out_valid", 32'(ifa.out_valid), 32'd1);
      check("stall_y_hold", 32'(ifa.y), 32'd1);
    end
    @(posedge clk);
    #1;
    ifa.out_ready = 1'b1;
    cycles(8);
    check("stall_count_a", 32'(qa.size()), 32'd4);
    check("stall_count_b", 32'(qb.size()), 32'd4);
    for (int i = 0; i < 4 && i < qa.size(); i++) begin
      check($sformatf("stall%0d_y_a", i), 32'(qa[i].y), 32'(stall_exp[i]));
      check($sformatf("stall%0d_gap", i),
            32'(i == 0 ? 1 : qa[i].cyc - qa[i-1].cyc), 32'd1);
    end
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      check($sformatf("stall%0d_y_b", i), 32'(qb[i].y), 32'(stall_exp[i]));
    end
    qa.delete();
    qb.delete();

    // Reset with two beats in flight.
    send(3'd7, 3'd7, 3'd7, 3'd7, 1'b0);
    send(3'd1, 3'd2, 3'd3, 3'd4, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("midrst_y_a", 32'(ifa.y), 32'd0);
    check("midrst_y_b", 32'(ifb.y), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(10);
    check("midrst_stale_a", 32'(qa.size()), 32'd0);
    check("midrst_stale_b", 32'(qb.size()), 32'd0);
    check("midrst_idle_valid", 32'(ifa.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
